// File: rtl/serial_subtractor.sv
// Bit-serial a - b: one full-subtractor step per clock, LSB first.
// Result, borrow and signed overflow register on completion only.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic accept, last;
  logic ai, bi, d, bout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign accept = start && (state_q != SHIFT);
  assign last   = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ai       = a_sh_q[0];
    bi       = b_sh_q[0];
    d        = ai ^ bi ^ bin_q;
    bout     = (~ai & bi) | (~(ai ^ bi) & bin_q);
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    if (accept) begin
      a_sh_d = a;
      b_sh_d = b;
      res_d  = '0;
      cnt_d  = '0;
      bin_d  = 1'b0;
    end else if (state_q == SHIFT) begin
      a_sh_d = a_sh_q >> 1;
      b_sh_d = b_sh_q >> 1;
      res_d  = {d, res_q[WIDTH-1:1]};
      bin_d  = bout;
      cnt_d  = cnt_q + 1'b1;
      // on the last step ai/bi are the operand MSBs and d is diff MSB
      if (last) begin
        diff_d   = {d, res_q[WIDTH-1:1]};
        borrow_d = bout;
        ovf_d    = (ai ^ bi) & (ai ^ d);
      end
    end
  end

  always_comb begin
    busy   = (state_q == SHIFT);
    done   = (state_q == DONE);
    diff   = diff_q;
    borrow = borrow_q;
    ovf    = ovf_q;
  end

endmodule
